spi_frame_scheduler: RTL and testbench

Sequences and arbitrates all 16-bit frames sent to the shared SPI serializer. Two requesters share it: a host single-write path, buffered in a small FIFO, and a configuration-table walker that streams `lut_len` words from an external registered LUT. Frames are granted round-robin, one frame per grant. The block drives the serializer's level `spi_start`/`spi_data` and consumes its `spi_end` pulse. It sits between the register-decode logic and the serializer, in the serializer's clock domain.

---
 rtl/spi_frame_scheduler_pkg.sv | 19 +
 rtl/spi_host_fifo.sv | 63 ++++++
 rtl/spi_frame_scheduler.sv | 173 +++++++++++++++++
 tb/tb_spi_frame_scheduler.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_frame_scheduler_pkg.sv
// Purpose: shared constants for the SPI frame scheduler (FSM states, requester ids, frame width).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_frame_scheduler_pkg;

    localparam int FRAME_W = 16;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_FETCH    = 3'd1;
    localparam logic [2:0] ST_START    = 3'd2;
    localparam logic [2:0] ST_WAIT_END = 3'd3;
    localparam logic [2:0] ST_GAP      = 3'd4;

    // requester ids, also used as the round-robin "last granted" value
    localparam logic REQ_H = 1'b0;
    localparam logic REQ_L = 1'b1;

endpackage

// File: rtl/spi_host_fifo.sv
// Purpose: synchronous FIFO buffering host frame words in front of the scheduler.
// Latency: a pushed word is visible (empty=0) the cycle after the push; pop_data is registered on pop.
// Backpressure: full is derived from registered occupancy only, so a pop never frees a slot in its own cycle.
// Ports: push/push_data (write side), pop/pop_data (read side), full/empty status flags.
module spi_host_fifo
    import spi_frame_scheduler_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk_i,
    input  logic               rst_n,
    input  logic               push,
    input  logic [FRAME_W-1:0] push_data,
    input  logic               pop,
    output logic [FRAME_W-1:0] pop_data,
    output logic               full,
    output logic               empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [FRAME_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        count;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            pop_data <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr   <= rd_ptr + AW'(1);
                pop_data <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spi_frame_scheduler.sv
// Purpose: round-robin arbiter/sequencer of 16-bit frames (host FIFO vs. LUT walker) onto one SPI serializer.
// Latency: host push -> spi_start in 2 cycles; lut_req -> spi_start in 3 cycles; GAP_CYCLES idle between frames.
// Backpressure: host_ready = FIFO not full; serializer holds us in WAIT_END until spi_end or TIMEOUT_CYCLES.
// Ports: host_valid/host_data/host_ready (host writes), lut_req/lut_len/lut_addr/lut_data/lut_busy/lut_done
//        (table walk), spi_start/spi_data/spi_end (serializer), err_timeout, frame_cnt (status).
module spi_frame_scheduler
    import spi_frame_scheduler_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 4095
) (
    input  logic               clk_i,
    input  logic               rst_n,
    input  logic               host_valid,
    input  logic [FRAME_W-1:0] host_data,
    output logic               host_ready,
    input  logic               lut_req,
    input  logic [7:0]         lut_len,
    output logic [7:0]         lut_addr,
    input  logic [FRAME_W-1:0] lut_data,
    output logic               lut_busy,
    output logic               lut_done,
    output logic               spi_start,
    output logic [FRAME_W-1:0] spi_data,
    input  logic               spi_end,
    output logic               err_timeout,
    output logic [15:0]        frame_cnt
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    logic [2:0]         state;
    logic               cur_src;
    logic               last_grant;
    logic [7:0]         lut_len_q;
    logic [FRAME_W-1:0] lut_word;
    logic [FRAME_W-1:0] fifo_word;
    logic [TW-1:0]      tmo_cnt;
    logic [GW-1:0]      gap_cnt;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               req_h;
    logic               req_l;
    logic               grant_h;
    logic               grant_l;
    logic               lut_accept;
    logic               lut_zero;
    logic               frame_over;
    logic               last_word;

    assign host_ready = ~fifo_full;
    assign push       = host_valid & host_ready;
    assign req_h      = ~fifo_empty;
    assign req_l      = lut_busy & (lut_addr < lut_len_q);
    // Contention goes to whoever was not granted last.
    assign grant_l    = (state == ST_IDLE) & req_l & (~req_h | (last_grant == REQ_H));
    assign grant_h    = (state == ST_IDLE) & req_h & ~grant_l;
    assign lut_accept = lut_req & ~lut_busy;
    assign lut_zero   = lut_accept & (lut_len == 8'd0);
    assign frame_over = (state == ST_WAIT_END) &
                        (spi_end | (tmo_cnt >= TW'(TIMEOUT_CYCLES - 1)));
    assign last_word  = ((lut_addr + 8'd1) == lut_len_q);

    // Host words land in the FIFO's registered read port, LUT words in lut_word;
    // both settle before spi_start rises and stay put until the next grant.
    assign spi_data = (cur_src == REQ_H) ? fifo_word : lut_word;

    spi_host_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (host_data),
        .pop       (grant_h),
        .pop_data  (fifo_word),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cur_src     <= REQ_H;
            last_grant  <= REQ_H;   // so the first contention goes to the LUT
            lut_len_q   <= '0;
            lut_addr    <= '0;
            lut_busy    <= 1'b0;
            lut_done    <= 1'b0;
            lut_word    <= '0;
            spi_start   <= 1'b0;
            err_timeout <= 1'b0;
            frame_cnt   <= '0;
            tmo_cnt     <= '0;
            gap_cnt     <= '0;
        end else begin
            lut_done    <= 1'b0;
            err_timeout <= 1'b0;

            if (lut_accept) begin
                if (lut_len == 8'd0) begin
                    lut_done <= 1'b1;
                end else begin
                    lut_busy  <= 1'b1;
                    lut_len_q <= lut_len;
                    lut_addr  <= '0;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (grant_l) begin
                        state      <= ST_FETCH;
                        cur_src    <= REQ_L;
                        last_grant <= REQ_L;
                    end else if (grant_h) begin
                        state      <= ST_START;
                        spi_start  <= 1'b1;
                        cur_src    <= REQ_H;
                        last_grant <= REQ_H;
                    end else if (lut_zero) begin
                        state   <= ST_GAP;
                        gap_cnt <= '0;
                    end
                end
                ST_FETCH: begin
                    lut_word  <= lut_data;
                    spi_start <= 1'b1;
                    state     <= ST_START;
                end
                ST_START: begin
                    // START is count 0 of the timeout window.
                    tmo_cnt <= TW'(1);
                    state   <= ST_WAIT_END;
                end
                ST_WAIT_END: begin
                    if (frame_over) begin
                        spi_start <= 1'b0;
                        state     <= ST_GAP;
                        gap_cnt   <= '0;
                        if (spi_end) begin
                            frame_cnt <= frame_cnt + 16'd1;
                        end else begin
                            err_timeout <= 1'b1;
                        end
                        if (cur_src == REQ_L) begin
                            if (last_word) begin
                                lut_addr <= '0;
                                lut_busy <= 1'b0;
                                lut_done <= 1'b1;
                            end else begin
                                lut_addr <= lut_addr + 8'd1;
                            end
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_scheduler.sv
// Purpose: directed self-checking bench for spi_frame_scheduler with a serializer model and registered ROM.
// Latency: n/a.
// Backpressure: host pushes honour host_ready; serializer model can stall spi_end.
module tb_spi_frame_scheduler;
    localparam int T_OUT = 4095;
    localparam int GAP   = 2;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic        host_valid;
    logic [15:0] host_data;
    logic        host_ready;
    logic        lut_req;
    logic [7:0]  lut_len;
    logic [7:0]  lut_addr;
    logic [15:0] lut_data;
    logic        lut_busy;
    logic        lut_done;
    logic        spi_start;
    logic [15:0] spi_data;
    logic        spi_end;
    logic        err_timeout;
    logic [15:0] frame_cnt;

    always #5 clk_i = ~clk_i;

    spi_frame_scheduler #(
        .FIFO_DEPTH     (4),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (T_OUT)
    ) dut (
        .clk_i       (clk_i),
        .rst_n       (rst_n),
        .host_valid  (host_valid),
        .host_data   (host_data),
        .host_ready  (host_ready),
        .lut_req     (lut_req),
        .lut_len     (lut_len),
        .lut_addr    (lut_addr),
        .lut_data    (lut_data),
        .lut_busy    (lut_busy),
        .lut_done    (lut_done),
        .spi_start   (spi_start),
        .spi_data    (spi_data),
        .spi_end     (spi_end),
        .err_timeout (err_timeout),
        .frame_cnt   (frame_cnt)
    );

    // registered external ROM
    logic [15:0] rom [256];
    always @(posedge clk_i) lut_data <= rom[lut_addr];

    int n_checks = 0;
    int n_fail   = 0;

    // serializer model: ends a frame ser_delay cycles into the spi_start window
    bit ser_stall = 1'b0;
    int ser_delay = 4;
    bit ser_end   = 1'b0;
    bit stray_end = 1'b0;
    int ser_cnt   = 0;
    assign spi_end = ser_end | stray_end;

    initial begin
        forever begin
            @(negedge clk_i);
            if (spi_start === 1'b1) begin
                ser_cnt++;
                ser_end = !ser_stall && (ser_cnt >= ser_delay);
            end else begin
                ser_cnt = 0;
                ser_end = 1'b0;
            end
        end
    end

    // frame monitor: records each spi_start window's word, min idle gap, stability, lut_done pulses
    logic [15:0] got [$];
    logic [15:0] cur_word;
    int min_gap  = 1000;
    int low_run  = 0;
    int done_cnt = 0;
    int clr_gen  = 0;
    int mon_gen  = 0;
    bit prev_start = 1'b0;
    bit seen_fall  = 1'b0;
    bit unstable   = 1'b0;

    initial begin
        forever begin
            @(negedge clk_i);
            if (mon_gen != clr_gen) begin
                mon_gen = clr_gen;
                got.delete();
                min_gap   = 1000;
                seen_fall = 1'b0;
                unstable  = 1'b0;
                done_cnt  = 0;
            end
            if (spi_start === 1'b1) begin
                if (!prev_start) begin
                    got.push_back(spi_data);
                    cur_word = spi_data;
                    if (seen_fall && low_run < min_gap) min_gap = low_run;
                end else if (spi_data !== cur_word) begin
                    unstable = 1'b1;
                end
                low_run = 0;
            end else begin
                if (prev_start) seen_fall = 1'b1;
                low_run++;
            end
            prev_start = (spi_start === 1'b1);
            if (lut_done === 1'b1) done_cnt++;
        end
    end

    task automatic clear_mon();
        clr_gen++;
        repeat (2) @(negedge clk_i);
    endtask

    task automatic push_word(input logic [15:0] d, output bit ok);
        ok = 1'b0;
        host_valid = 1'b1;
        host_data  = d;
        for (int i = 0; i < 300; i++) begin
            if (host_ready === 1'b1) begin
                @(negedge clk_i);
                ok = 1'b1;
                break;
            end
            @(negedge clk_i);
        end
        host_valid = 1'b0;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (spi_start === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk_i);
        end
    endtask

    task automatic wait_frames(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_i);
            if (got.size() >= n && spi_start === 1'b0) begin ok = 1'b1; break; end
        end
        repeat (GAP + 4) @(negedge clk_i);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; host_valid = 1'b0; host_data = '0; lut_req = 1'b0; lut_len = '0;
        repeat (3) @(negedge clk_i);
        n_checks++; if (host_ready !== 1'b1) begin n_fail++; $display("FAIL reset_host_ready: got %b want 1", host_ready); end
        n_checks++; if (lut_addr !== 8'h00) begin n_fail++; $display("FAIL reset_lut_addr: got %h want 00", lut_addr); end
        n_checks++; if (lut_busy !== 1'b0) begin n_fail++; $display("FAIL reset_lut_busy: got %b want 0", lut_busy); end
        n_checks++; if (lut_done !== 1'b0) begin n_fail++; $display("FAIL reset_lut_done: got %b want 0", lut_done); end
        n_checks++; if (spi_start !== 1'b0) begin n_fail++; $display("FAIL reset_spi_start: got %b want 0", spi_start); end
        n_checks++; if (spi_data !== 16'h0000) begin n_fail++; $display("FAIL reset_spi_data: got %h want 0000", spi_data); end
        n_checks++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_err_timeout: got %b want 0", err_timeout); end
        n_checks++; if (frame_cnt !== 16'h0000) begin n_fail++; $display("FAIL reset_frame_cnt: got %h want 0000", frame_cnt); end
        rst_n = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_host_single();
        bit ok;
        int win;
        ser_stall = 1'b0; ser_delay = 32;
        clear_mon();
        host_valid = 1'b1; host_data = 16'h1234;      // cycle 0
        @(negedge clk_i);                             // cycle 1: grant
        host_valid = 1'b0;
        n_checks++; if (spi_start !== 1'b0) begin n_fail++; $display("FAIL host_c1_start: got %b want 0", spi_start); end
        @(negedge clk_i);                             // cycle 2: START
        n_checks++; if (spi_start !== 1'b1) begin n_fail++; $display("FAIL host_c2_start: got %b want 1", spi_start); end
        n_checks++; if (spi_data !== 16'h1234) begin n_fail++; $display("FAIL host_data: got %h want 1234", spi_data); end
        win = 1; ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            if (spi_start === 1'b0) begin ok = 1'b1; break; end
            win++;
        end
        n_checks++; if (!ok) begin n_fail++; $display("FAIL host_end_wait: got timeout want spi_start low"); end
        n_checks++; if (win != 32) begin n_fail++; $display("FAIL host_window: got %0d want 32", win); end
        n_checks++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL host_frame_cnt: got %0d want 1", frame_cnt); end
        repeat (4) @(negedge clk_i);
        n_checks++; if (got.size() != 1) begin n_fail++; $display("FAIL host_windows: got %0d want 1", got.size()); end
    endtask

    task automatic test_lut_walk();
        bit ok;
        logic [15:0] exp_w [3];
        exp_w = '{16'h0000, 16'h0020, 16'h1140};
        rom[0] = 16'h0000; rom[1] = 16'h0020; rom[2] = 16'h1140;
        ser_delay = 5;
        clear_mon();
        lut_req = 1'b1; lut_len = 8'd3;               // cycle 0
        @(negedge clk_i);                             // cycle 1: grant
        lut_req = 1'b0; lut_len = 8'd0;
        n_checks++; if (lut_busy !== 1'b1) begin n_fail++; $display("FAIL lut_busy_set: got %b want 1", lut_busy); end
        @(negedge clk_i);                             // cycle 2: FETCH
        n_checks++; if (spi_start !== 1'b0) begin n_fail++; $display("FAIL lut_fetch_start: got %b want 0", spi_start); end
        @(negedge clk_i);                             // cycle 3: START
        n_checks++; if (spi_start !== 1'b1) begin n_fail++; $display("FAIL lut_c3_start: got %b want 1", spi_start); end
        wait_frames(3, 300, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL lut_wait: got timeout want 3 frames"); end
        n_checks++; if (got.size() != 3) begin n_fail++; $display("FAIL lut_frames: got %0d want 3", got.size()); end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            n_checks++; if (got[i] !== exp_w[i]) begin n_fail++; $display("FAIL lut_word%0d: got %h want %h", i, got[i], exp_w[i]); end
        end
        n_checks++; if (min_gap < GAP) begin n_fail++; $display("FAIL lut_gap: got %0d want >=%0d", min_gap, GAP); end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL lut_done_cnt: got %0d want 1", done_cnt); end
        n_checks++; if (lut_busy !== 1'b0) begin n_fail++; $display("FAIL lut_busy_end: got %b want 0", lut_busy); end
        n_checks++; if (lut_addr !== 8'd0) begin n_fail++; $display("FAIL lut_addr_end: got %0d want 0", lut_addr); end
        n_checks++; if (frame_cnt !== 16'd4) begin n_fail++; $display("FAIL lut_frame_cnt: got %0d want 4", frame_cnt); end
    endtask

    task automatic test_fifo_full();
        bit ok;
        ser_stall = 1'b1; ser_delay = 3;
        clear_mon();
        push_word(16'hB000, ok);
        wait_start(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL full_prime: got no start want start"); end
        for (int i = 1; i <= 4; i++) begin
            host_valid = 1'b1; host_data = 16'hB000 + 16'(i);
            n_checks++; if (host_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready%0d: got %b want 1", i, host_ready); end
            @(negedge clk_i);
        end
        host_valid = 1'b1; host_data = 16'hB005;
        n_checks++; if (host_ready !== 1'b0) begin n_fail++; $display("FAIL full_after4: got %b want 0", host_ready); end
        repeat (5) @(negedge clk_i);
        n_checks++; if (host_ready !== 1'b0) begin n_fail++; $display("FAIL full_held: got %b want 0", host_ready); end
        ser_stall = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (host_ready === 1'b1) begin @(negedge clk_i); ok = 1'b1; break; end
            @(negedge clk_i);
        end
        host_valid = 1'b0;
        n_checks++; if (!ok) begin n_fail++; $display("FAIL full_5th_accept: got timeout want accept"); end
        wait_frames(6, 500, ok);
        n_checks++; if (got.size() != 6) begin n_fail++; $display("FAIL full_frames: got %0d want 6", got.size()); end
        for (int i = 0; i < 6 && i < got.size(); i++) begin
            n_checks++; if (got[i] !== 16'hB000 + 16'(i)) begin n_fail++; $display("FAIL full_word%0d: got %h want %h", i, got[i], 16'hB000 + 16'(i)); end
        end
        n_checks++; if (unstable !== 1'b0) begin n_fail++; $display("FAIL full_stable: got %b want 0", unstable); end
        n_checks++; if (frame_cnt !== 16'd10) begin n_fail++; $display("FAIL full_frame_cnt: got %0d want 10", frame_cnt); end
    endtask

    task automatic test_interleave();
        bit ok;
        logic [15:0] exp_w [6];
        exp_w = '{16'hC000, 16'hA001, 16'hC001, 16'hA002, 16'hC002, 16'hC003};
        rom[0] = 16'hC000; rom[1] = 16'hC001; rom[2] = 16'hC002; rom[3] = 16'hC003;
        ser_stall = 1'b0; ser_delay = 4;
        clear_mon();
        lut_req = 1'b1; lut_len = 8'd4; host_valid = 1'b1; host_data = 16'hA001;
        @(negedge clk_i);
        lut_req = 1'b0; host_data = 16'hA002;
        @(negedge clk_i);
        host_valid = 1'b0;
        wait_frames(6, 500, ok);
        n_checks++; if (got.size() != 6) begin n_fail++; $display("FAIL mix_frames: got %0d want 6", got.size()); end
        for (int i = 0; i < 6 && i < got.size(); i++) begin
            n_checks++; if (got[i] !== exp_w[i]) begin n_fail++; $display("FAIL mix_word%0d: got %h want %h", i, got[i], exp_w[i]); end
        end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL mix_done_cnt: got %0d want 1", done_cnt); end
        n_checks++; if (frame_cnt !== 16'd16) begin n_fail++; $display("FAIL mix_frame_cnt: got %0d want 16", frame_cnt); end
    endtask

    task automatic test_timeout();
        bit ok;
        int k;
        logic [15:0] fc;
        ser_stall = 1'b1;
        clear_mon();
        fc = frame_cnt;
        push_word(16'hD00D, ok);
        wait_start(ok);
        k = 0; ok = 1'b0;
        for (int i = 0; i < T_OUT + 50; i++) begin
            @(negedge clk_i);
            k++;
            if (err_timeout === 1'b1) begin ok = 1'b1; break; end
        end
        n_checks++; if (!ok) begin n_fail++; $display("FAIL tmo_seen: got no pulse want pulse"); end
        n_checks++; if (k != T_OUT) begin n_fail++; $display("FAIL tmo_delay: got %0d want %0d", k, T_OUT); end
        n_checks++; if (spi_start !== 1'b0) begin n_fail++; $display("FAIL tmo_start_drop: got %b want 0", spi_start); end
        @(negedge clk_i);
        n_checks++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_pulse_width: got %b want 0", err_timeout); end
        n_checks++; if (frame_cnt !== fc) begin n_fail++; $display("FAIL tmo_frame_cnt: got %0d want %0d", frame_cnt, fc); end
        ser_stall = 1'b0; ser_delay = 4;
        push_word(16'hD00E, ok);
        wait_frames(2, 200, ok);
        n_checks++; if (got.size() != 2 || got[1] !== 16'hD00E) begin n_fail++; $display("FAIL tmo_next_frame: got %0d frames want D00E second", got.size()); end
        n_checks++; if (frame_cnt !== fc + 16'd1) begin n_fail++; $display("FAIL tmo_next_cnt: got %0d want %0d", frame_cnt, fc + 16'd1); end
        // zero-length walk
        lut_req = 1'b1; lut_len = 8'd0;
        @(negedge clk_i);
        lut_req = 1'b0;
        n_checks++; if (lut_done !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %b want 1", lut_done); end
        n_checks++; if (lut_busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy: got %b want 0", lut_busy); end
        @(negedge clk_i);
        n_checks++; if (lut_done !== 1'b0) begin n_fail++; $display("FAIL zero_done_width: got %b want 0", lut_done); end
        // stray spi_end while idle
        stray_end = 1'b1;
        @(negedge clk_i);
        stray_end = 1'b0;
        repeat (10) @(negedge clk_i);
        n_checks++; if (got.size() != 2) begin n_fail++; $display("FAIL zero_no_frame: got %0d want 2", got.size()); end
        n_checks++; if (frame_cnt !== fc + 16'd1) begin n_fail++; $display("FAIL stray_end_cnt: got %0d want %0d", frame_cnt, fc + 16'd1); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        ser_stall = 1'b1;
        clear_mon();
        push_word(16'hE001, ok);
        wait_start(ok);
        push_word(16'hE002, ok);
        rom[0] = 16'hF000; rom[1] = 16'hF001;
        lut_req = 1'b1; lut_len = 8'd2;
        @(negedge clk_i);
        lut_req = 1'b0;
        n_checks++; if (lut_busy !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_before: got %b want 1", lut_busy); end
        repeat (3) @(negedge clk_i);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (spi_start !== 1'b0) begin n_fail++; $display("FAIL rmid_start: got %b want 0", spi_start); end
        n_checks++; if (host_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %b want 1", host_ready); end
        n_checks++; if (lut_busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", lut_busy); end
        n_checks++; if (spi_data !== 16'h0000) begin n_fail++; $display("FAIL rmid_data: got %h want 0000", spi_data); end
        n_checks++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL rmid_frame_cnt: got %0d want 0", frame_cnt); end
        @(negedge clk_i);
        rst_n = 1'b1; ser_stall = 1'b0; ser_delay = 4;
        @(negedge clk_i);
        clear_mon();
        push_word(16'hE100, ok);
        wait_frames(1, 200, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rmid_wait: got timeout want frame"); end
        repeat (20) @(negedge clk_i);
        n_checks++; if (got.size() != 1) begin n_fail++; $display("FAIL rmid_frames: got %0d want 1", got.size()); end
        n_checks++; if (got.size() > 0 && got[0] !== 16'hE100) begin n_fail++; $display("FAIL rmid_word: got %h want E100", got[0]); end
        n_checks++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL rmid_after_cnt: got %0d want 1", frame_cnt); end
        n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL rmid_no_done: got %0d want 0", done_cnt); end
    endtask

    initial begin
        test_reset();
        test_host_single();
        test_lut_walk();
        test_fifo_full();
        test_interleave();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
